// File: rtl/tft_pattern_gen.sv
// tft_pattern_gen: registered test-pattern generator for a TFT raster with a frame-aligned mode handshake.
// Define TFT_PAT_BLINK_EN to build the blinking mode-3 pattern; otherwise mode 3 is steady red.
module tft_pattern_gen #(
    parameter int H_START      = 210,
    parameter int H_END        = 1010,
    parameter int V_START      = 22,
    parameter int V_END        = 480,
    parameter int BORDER       = 3,
    parameter int INSET        = 100,
    parameter int COLOR_W      = 8,
    parameter int BLINK_FRAMES = 30
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [10:0]        counter_h,
    input  logic [9:0]         counter_v,
    input  logic               den,
    input  logic [1:0]         mode_req,
    input  logic               mode_valid,
    output logic               mode_ready,
    output logic [COLOR_W-1:0] R,
    output logic [COLOR_W-1:0] G,
    output logic [COLOR_W-1:0] B,
    output logic [1:0]         mode,
    output logic               frame_tick,
    output logic               blink_phase
);
    localparam int AW = 16;
    localparam int CH = (H_START + H_END) / 2;
    localparam int CV = (V_START + V_END) / 2;
    localparam logic [COLOR_W-1:0] FULL = '1;
    localparam logic [COLOR_W-1:0] HALF = FULL >> 1;

    function automatic logic in_span(input logic [AW-1:0] x, input int lo, input int hi);
        return (x >= AW'(lo)) && (x < AW'(hi));
    endfunction

    logic [AW-1:0]      h;
    logic [AW-1:0]      v;
    logic               in_win;
    logic               on_border;
    logic               on_inset;
    logic               on_trident;
    logic [AW-1:0]      dh_x8;
    logic [7:1]         bar_ge;
    logic [2:0]         bar_idx;
    logic [COLOR_W-1:0] r_next, g_next, b_next;
    logic [COLOR_W-1:0] r_reg, g_reg, b_reg;
    logic [1:0]         mode_reg;
    logic [1:0]         pend_mode_reg;
    logic               pend_valid_reg;
    logic               pend_valid_next;
    logic               mode_ready_reg;
    logic               frame_tick_reg;
    logic               accept;
    logic               apply;

    assign h = AW'(counter_h);
    assign v = AW'(counter_v);

    assign in_win    = den && in_span(h, H_START, H_END) && in_span(v, V_START, V_END);
    assign on_border = !in_span(h, H_START + BORDER, H_END - BORDER) ||
                       !in_span(v, V_START + BORDER, V_END - BORDER);
    assign on_inset  = in_span(h, H_START + INSET, H_START + INSET + BORDER) ||
                       in_span(h, H_END - INSET - BORDER, H_END - INSET) ||
                       in_span(v, V_START + INSET, V_START + INSET + BORDER) ||
                       in_span(v, V_END - INSET - BORDER, V_END - INSET);
    assign on_trident = (in_span(h, CH - BORDER, CH + BORDER) && in_span(v, CV - 80, CV + 50)) ||
                        ((in_span(h, CH - 30 - BORDER, CH - 30 + BORDER) ||
                          in_span(h, CH + 30 - BORDER, CH + 30 + BORDER)) && in_span(v, CV - 50, CV));

    // Bar index = number of bar boundaries passed, i.e. floor(8*(h-H_START)/width) without a divider.
    assign dh_x8 = (h - AW'(H_START)) << 3;

    genvar gi;
    generate
        for (gi = 1; gi < 8; gi++) begin : g_bar
            assign bar_ge[gi] = dh_x8 >= AW'(gi * (H_END - H_START));
        end
    endgenerate

    always_comb begin
        bar_idx = '0;
        for (int i = 1; i < 8; i++) begin
            bar_idx = bar_idx + {2'b00, bar_ge[i]};
        end
    end

    always_comb begin
        r_next = '0;
        g_next = '0;
        b_next = '0;
        if (in_win && !on_border && !(mode_reg != 2'd0 && on_inset) && !(mode_reg[1] && on_trident)) begin
            case (mode_reg)
                // Bar order white..black maps to R=~idx[1], G=~idx[2], B=~idx[0].
                2'd0: begin
                    r_next = {COLOR_W{~bar_idx[1]}};
                    g_next = {COLOR_W{~bar_idx[2]}};
                    b_next = {COLOR_W{~bar_idx[0]}};
                end
                2'd1: g_next = FULL;
                2'd2: begin
                    r_next = FULL;
                    g_next = HALF;
                end
                default: r_next = blink_phase ? FULL : '0;
            endcase
        end
    end

    // A request accepted while frame_tick is high is not yet pending, so it waits a full frame.
    assign accept = mode_valid && mode_ready_reg;
    assign apply  = frame_tick_reg && pend_valid_reg;
    assign pend_valid_next = accept ? 1'b1 : (apply ? 1'b0 : pend_valid_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg          <= '0;
            g_reg          <= '0;
            b_reg          <= '0;
            mode_reg       <= '0;
            pend_mode_reg  <= '0;
            pend_valid_reg <= 1'b0;
            mode_ready_reg <= 1'b0;
            frame_tick_reg <= 1'b0;
        end else begin
            r_reg          <= r_next;
            g_reg          <= g_next;
            b_reg          <= b_next;
            frame_tick_reg <= (counter_h == 11'd0) && (counter_v == 10'd0);
            pend_valid_reg <= pend_valid_next;
            mode_ready_reg <= !pend_valid_next;
            if (accept) begin
                pend_mode_reg <= mode_req;
            end
            if (apply) begin
                mode_reg <= pend_mode_reg;
            end
        end
    end

`ifdef TFT_PAT_BLINK_EN
    logic [7:0] blink_cnt_reg;
    logic       blink_phase_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b1;
        end else if (frame_tick_reg) begin
            if (apply && pend_mode_reg != mode_reg) begin
                blink_cnt_reg <= '0;
            end else if (blink_cnt_reg == 8'(BLINK_FRAMES - 1)) begin
                blink_cnt_reg   <= '0;
                blink_phase_reg <= !blink_phase_reg;
            end else begin
                blink_cnt_reg <= blink_cnt_reg + 8'd1;
            end
        end
    end

    assign blink_phase = blink_phase_reg;
`else
    assign blink_phase = 1'b1;
`endif

    assign R          = r_reg;
    assign G          = g_reg;
    assign B          = b_reg;
    assign mode       = mode_reg;
    assign mode_ready = mode_ready_reg;
    assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_tft_pattern_gen.sv
// Randomized bench for tft_pattern_gen against a frame-level reference model, plus directed feature checks.
// Blink expectations follow TFT_PAT_BLINK_EN exactly as the design build does.
module tb_tft_pattern_gen;
    localparam int HS = 210, HE = 1010, VS = 22, VE = 480, BD = 3, IN = 100, BF = 30;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] counter_h = '0;
    logic [9:0]  counter_v = '0;
    logic        den = 1'b0;
    logic [1:0]  mode_req = '0;
    logic        mode_valid = 1'b0;
    logic        mode_ready;
    logic [7:0]  R, G, B;
    logic [1:0]  mode;
    logic        frame_tick;
    logic        blink_phase;

    always #5 clk = ~clk;

    tft_pattern_gen #(
        .H_START(HS), .H_END(HE), .V_START(VS), .V_END(VE),
        .BORDER(BD), .INSET(IN), .COLOR_W(8), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .rst(rst), .counter_h(counter_h), .counter_v(counter_v), .den(den),
        .mode_req(mode_req), .mode_valid(mode_valid), .mode_ready(mode_ready),
        .R(R), .G(G), .B(B), .mode(mode), .frame_tick(frame_tick), .blink_phase(blink_phase)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference state: what each output should show after the most recent edge.
    int m_rgb = 0, m_mode = 0, m_ready = 0, m_tick = 0, m_phase = 1;
    int m_pend_valid = 0, m_pend_mode = 0, m_frames = 0;

    task automatic check(input string tag, input int obs, input int exp_v);
        n_vec++;
        if (obs != exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    function automatic bit in_span(input int x, input int lo, input int hi);
        return (x >= lo) && (x < hi);
    endfunction

    function automatic int ref_pixel(input int h, input int v, input int d, input int m, input int ph);
        int ch, cv, idx;
        ch = (HS + HE) / 2;
        cv = (VS + VE) / 2;
        if (d == 0 || !in_span(h, HS, HE) || !in_span(v, VS, VE)) return 0;
        if (h < HS + BD || h >= HE - BD || v < VS + BD || v >= VE - BD) return 0;
        if (m >= 1 && (in_span(h, HS + IN, HS + IN + BD) || in_span(h, HE - IN - BD, HE - IN) ||
                       in_span(v, VS + IN, VS + IN + BD) || in_span(v, VE - IN - BD, VE - IN))) return 0;
        if (m >= 2) begin
            if (in_span(h, ch - BD, ch + BD) && in_span(v, cv - 80, cv + 50)) return 0;
            if ((in_span(h, ch - 30 - BD, ch - 30 + BD) || in_span(h, ch + 30 - BD, ch + 30 + BD)) &&
                in_span(v, cv - 50, cv)) return 0;
        end
        case (m)
            0: begin
                idx = ((h - HS) * 8) / (HE - HS);
                case (idx)
                    0: return 32'hFFFFFF;
                    1: return 32'hFFFF00;
                    2: return 32'h00FFFF;
                    3: return 32'h00FF00;
                    4: return 32'hFF00FF;
                    5: return 32'hFF0000;
                    6: return 32'h0000FF;
                    default: return 0;
                endcase
            end
            1: return 32'h00FF00;
            2: return 32'hFF7F00;
            default: return (ph != 0) ? 32'hFF0000 : 0;
        endcase
    endfunction

    task automatic model_step(input int h, input int v, input int d, input int mv, input int mr, input int r);
        int accepted, new_mode;
        if (r != 0) begin
            m_rgb = 0; m_mode = 0; m_ready = 0; m_tick = 0; m_phase = 1;
            m_pend_valid = 0; m_pend_mode = 0; m_frames = 0;
        end else begin
            accepted = (mv != 0 && m_ready != 0) ? 1 : 0;
            m_rgb = ref_pixel(h, v, d, m_mode, m_phase);
            new_mode = m_mode;
            if (m_tick != 0) begin
                if (m_pend_valid != 0) begin
                    new_mode = m_pend_mode;
                    m_pend_valid = 0;
                end
`ifdef TFT_PAT_BLINK_EN
                if (new_mode != m_mode) begin
                    m_frames = 0;
                end else begin
                    m_frames++;
                    if (m_frames == BF) begin
                        m_frames = 0;
                        m_phase = 1 - m_phase;
                    end
                end
`endif
            end
            m_mode = new_mode;
            if (accepted != 0) begin
                m_pend_valid = 1;
                m_pend_mode = mr;
            end
            m_ready = (m_pend_valid != 0) ? 0 : 1;
            m_tick = (h == 0 && v == 0) ? 1 : 0;
        end
    endtask

    // Called at a falling edge: drive, let the DUT sample, compare all outputs at the next falling edge.
    task automatic cycle(input int h, input int v, input int d, input int mv, input int mr, input int r);
        counter_h  = 11'(h);
        counter_v  = 10'(v);
        den        = (d != 0);
        mode_valid = (mv != 0);
        mode_req   = 2'(mr);
        rst        = (r != 0);
        @(posedge clk);
        model_step(h, v, d, mv, mr, r);
        @(negedge clk);
        check("rgb", int'({R, G, B}), m_rgb);
        check("mode", int'(mode), m_mode);
        check("ready", int'(mode_ready), m_ready);
        check("tick", int'(frame_tick), m_tick);
        check("phase", int'(blink_phase), m_phase);
    endtask

    task automatic idle();
        cycle(5, 5, 0, 0, 0, 0);
    endtask

    task automatic set_mode(input int m);
        cycle(5, 5, 0, 1, m, 0);
        cycle(0, 0, 0, 0, 0, 0);
        idle();
        check("set_mode", int'(mode), m);
    endtask

    initial begin
        int h, v, n, exp_rgb;
        @(negedge clk);

        // Reset state and single-cycle latency in mode 0.
        cycle(610, 100, 1, 0, 0, 1);
        cycle(610, 100, 1, 1, 2, 1);
        check("rst_rgb", int'({R, G, B}), 0);
        check("rst_mode", int'(mode), 0);
        check("rst_ready", int'(mode_ready), 0);
        check("rst_tick", int'(frame_tick), 0);
        check("rst_phase", int'(blink_phase), 1);
        cycle(610, 100, 1, 0, 0, 0);
        check("ready_after_rst", int'(mode_ready), 1);
        check("bar4_magenta", int'({R, G, B}), 32'hFF00FF);

        // Border and inset lines in mode 1.
        set_mode(1);
        cycle(211, 300, 1, 0, 0, 0);
        check("border", int'({R, G, B}), 0);
        cycle(311, 300, 1, 0, 0, 0);
        check("inset", int'({R, G, B}), 0);
        cycle(400, 300, 1, 0, 0, 0);
        check("green_bg", int'({R, G, B}), 32'h00FF00);

        // Trident in mode 2.
        set_mode(2);
        cycle(610, 200, 1, 0, 0, 0);
        check("stem", int'({R, G, B}), 0);
        cycle(580, 230, 1, 0, 0, 0);
        check("prong", int'({R, G, B}), 0);
        cycle(580, 260, 1, 0, 0, 0);
        check("amber_bg", int'({R, G, B}), 32'hFF7F00);

        // Mid-frame request holds until the frame tick.
        idle();
        cycle(400, 300, 1, 1, 3, 0);
        check("hs_ready_drop", int'(mode_ready), 0);
        check("hs_mode_hold", int'(mode), 2);
        idle();
        cycle(0, 0, 0, 0, 0, 0);
        check("hs_tick", int'(frame_tick), 1);
        check("hs_mode_at_tick", int'(mode), 2);
        idle();
        check("hs_mode_new", int'(mode), 3);
        check("hs_ready_back", int'(mode_ready), 1);

        // Request accepted in the frame_tick cycle waits one more frame.
        idle();
        cycle(0, 0, 0, 0, 0, 0);
        cycle(5, 5, 0, 1, 1, 0);
        check("tickreq_mode_hold", int'(mode), 3);
        check("tickreq_ready", int'(mode_ready), 0);
        idle();
        cycle(0, 0, 0, 0, 0, 0);
        idle();
        check("tickreq_next_frame", int'(mode), 1);

        // Reset while a request is pending discards it.
        cycle(5, 5, 0, 1, 2, 0);
        cycle(400, 300, 1, 0, 0, 1);
        check("mrst_mode", int'(mode), 0);
        check("mrst_rgb", int'({R, G, B}), 0);
        cycle(400, 300, 1, 0, 0, 1);
        cycle(400, 300, 1, 0, 0, 0);
        check("mrst_ready", int'(mode_ready), 1);
        cycle(0, 0, 0, 0, 0, 0);
        idle();
        idle();
        check("mrst_discard", int'(mode), 0);

        // Blink in mode 3: 30 frames red, 30 black, then red again (steady red without blink).
        cycle(5, 5, 0, 0, 0, 1);
        idle();
        cycle(5, 5, 0, 1, 3, 0);
        for (int f = 0; f < 95; f++) begin
            cycle(0, 0, 0, 0, 0, 0);
            idle();
            cycle(400, 300, 1, 0, 0, 0);
`ifdef TFT_PAT_BLINK_EN
            exp_rgb = ((f / BF) % 2 == 0) ? 32'hFF0000 : 0;
`else
            exp_rgb = 32'hFF0000;
`endif
            check($sformatf("blink_f%0d", f), int'({R, G, B}), exp_rgb);
        end

        // Randomized frames with random positions, den, requests and occasional resets.
        for (int f = 0; f < 300; f++) begin
            cycle(0, 0, $urandom_range(0, 1), ($urandom_range(0, 3) == 0), $urandom_range(0, 3), 0);
            n = $urandom_range(2, 10);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 1) == 0) begin
                    h = $urandom_range(570, 650);
                    v = $urandom_range(160, 310);
                end else begin
                    h = $urandom_range(HS - 5, HE + 5);
                    v = $urandom_range(VS - 5, VE + 5);
                end
                cycle(h, v, ($urandom_range(0, 7) != 0), ($urandom_range(0, 5) == 0),
                      $urandom_range(0, 3), ($urandom_range(0, 299) == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
